// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage load/store bus: a word-organised RAM with
// big-endian byte lanes, a configurable access latency and a stall request to pipeline control.
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                  state_r, state_nxt_s;
  logic [3:0]              cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    we_r;
  logic [3:0]              sel_r;
  logic [31:0]             data_r;
  logic [31:0]             mem_r [0:DEPTH-1];

  logic                    do_acc_s;
  logic [ADDR_WIDTH-1:0]   acc_idx_s;
  logic                    acc_we_s;
  logic [3:0]              acc_sel_s;
  logic [31:0]             acc_data_s;
  logic                    unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // With no wait cycles the access happens on the capture edge, so it must see the live inputs.
  assign acc_idx_s  = (state_r == ST_IDLE) ? addr_i[ADDR_WIDTH+1:2] : addr_r;
  assign acc_we_s   = (state_r == ST_IDLE) ? we_i   : we_r;
  assign acc_sel_s  = (state_r == ST_IDLE) ? sel_i  : sel_r;
  assign acc_data_s = (state_r == ST_IDLE) ? data_i : data_r;

  // Next-state, stall request and access strobe.
  always_comb begin
    state_nxt_s = state_r;
    stallreq_o  = 1'b0;
    do_acc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ce_i) begin
          stallreq_o = 1'b1;
          if (NO_WAIT) begin
            state_nxt_s = ST_DONE;
            do_acc_s    = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stallreq_o = 1'b1;
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_DONE;
          do_acc_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, wait counter, request capture and registered read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      data_r  <= 32'd0;
      data_o  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && ce_i) begin
        cnt_r  <= CNT_INIT;
        addr_r <= addr_i[ADDR_WIDTH+1:2];
        we_r   <= we_i;
        sel_r  <= sel_i;
        data_r <= data_i;
      end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (do_acc_s) begin
        data_o <= acc_we_s ? 32'd0 : mem_r[acc_idx_s];
      end
    end
  end

  // Byte-lane array write; the array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && do_acc_s && acc_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= acc_data_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder on the far end of the MEM-stage load/store bus (ce/we/addr/sel/data).
- Holds a word-organised RAM with big-endian byte-lane writes.
- Models a configurable access latency by raising a stall request to pipeline control until each access completes.
- Returns the full 32-bit read word; byte/halfword extraction and sign-extension stay in the MEM stage.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, extra wait cycles per access (legal 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high (`RstEnable = 1'b1).
- ce_i  input  1  chip enable from MEM stage; 1 = access requested.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address.
- sel_i  input  4  byte-lane select; sel_i[3] = bits 31:24 … sel_i[0] = bits 7:0.
- data_i  input  32  write data, lane-replicated by the MEM stage.
- data_o  output  32  registered read word.
- stallreq_o  output  1  stall request to pipeline control.

Behaviour:
- Word index = addr_i[ADDR_WIDTH+1:2]. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so upper addresses alias.
- FSM states: IDLE, WAIT, DONE. 4-bit counter cnt. Request registers: addr, we, sel, data.
- IDLE:
  - ce_i=0: stay in IDLE; stallreq_o=0.
  - ce_i=1: stallreq_o=1 combinationally in this same cycle. Capture addr_i/we_i/sel_i/data_i at the clock edge.
  - Next state: DONE if WAIT_CYCLES==0; otherwise WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - stallreq_o=1.
  - cnt!=0: cnt decrements.
  - cnt==0: go to DONE, and the array access is performed on that edge.
- Array access (on the edge entering DONE, from either IDLE or WAIT):
  - Write: each lane with sel=1 takes the matching data byte; lanes with sel=0 are unchanged; sel=0000 changes nothing. data_o <= 0.
  - Read: data_o <= array[index], all 32 bits, regardless of sel.
- DONE:
  - stallreq_o=0, so the pipeline advances at this edge.
  - data_o is valid throughout this cycle.
  - Unconditional next state is IDLE; inputs present in DONE are ignored.
- Stall length per access = 1 + WAIT_CYCLES cycles. data_o is valid in the following (DONE) cycle.
- Back-to-back accesses: a request seen in IDLE right after DONE starts a new access. Read-after-write returns the newly written data.
- Input changes (including ce_i dropping) after capture are ignored; the captured access always completes.
- data_o holds its value outside DONE, changing only on the edge entering DONE.
- Reset (asserted at any time, including mid-WAIT):
  - state=IDLE, cnt=0, data_o=0, stallreq_o=0 immediately.
  - A pending access is discarded with no write.
  - Array contents are not reset.
- No X on outputs after reset. The array is uninitialised until written; the bench writes before reading.

Test Plan:
1. Assert rst mid-operation → stallreq_o=0 and data_o=0x00000000 asynchronously. After release, the FSM is in IDLE with no access pending.
2. WAIT_CYCLES=2: SW addr 0x10, data 0x11223344, sel 1111 → stallreq_o high exactly 3 cycles, then DONE. Next, LW addr 0x10 → data_o=0x11223344 in its DONE cycle.
3. After test 2, SB addr 0x11, data 0xAAAAAAAA, sel 0100, then read 0x10 → 0x11AA3344. SH sel 0011 with data 0x55665566, then read → 0x11AA5566.
4. Aliasing, ADDR_WIDTH=10: read addr 0x1010 → same word as 0x10 (0x11AA5566). Write sel 0000 to 0x10 → contents unchanged.
5. Drop ce_i and change addr/data in the first WAIT cycle of a write to 0x20 with 0xDEADBEEF → write still lands; a later read of 0x20 returns 0xDEADBEEF. Separately, assert rst during WAIT of a write of 0x12345678 to 0x24 → a later read of 0x24 returns the old value.
6. WAIT_CYCLES=0: read → stallreq_o high 1 cycle, data valid next cycle. Two back-to-back reads with ce_i held high → stall pattern 1,0,1,0.
